// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
//
// One 7-bit segment bus is time-shared across NUM_DIGITS common-cathode digits.
// Each digit is lit for DWELL cycles and then followed by BLANK all-off cycles.
// Digit values are written into a pending shadow buffer. That buffer moves into
// the active buffer only at a frame boundary, so a frame never mixes old and
// new digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (all except digit 0) show segments=0
//   while their digit_sel still asserts.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   enable       scan enable; low forces IDLE
//   wr_valid     write request
//   wr_ready     pending buffer empty (write can be accepted)
//   wr_data      4*NUM_DIGITS nibbles, digit 0 = [3:0]
//   segments     active-high a..g (bit0=a)
//   digit_sel    one-hot active digit, zero when blank/idle
//   frame_done   one-cycle pulse on the last cycle of each frame
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 100,
  parameter int BLANK      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [4*NUM_DIGITS-1:0]   wr_data,
  output logic [6:0]                segments,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      frame_done
);

  typedef enum logic [1:0] {IDLE, SCAN, GUARD} state_t;

  localparam int MAXDB = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW    = $clog2(MAXDB + 1);
  localparam int IW    = $clog2(NUM_DIGITS);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST  = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  state_t            state, state_d;
  logic [IW-1:0]     idx, idx_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [DW-1:0]     active, active_d, pending, pending_d;
  logic              pending_full, pfull_d;
  logic [6:0]        seg_d;
  logic [NUM_DIGITS-1:0] dsel_d;
  logic              fd_d, xfer, fe_now;

  // True on the final cycle of a frame for the given position.
  function automatic logic is_last(state_t s, logic [IW-1:0] i, logic [CW-1:0] c);
    if (i != IDX_LAST) return 1'b0;
    if (BLANK == 0)    return (s == SCAN) && (c == DW_LAST);
    return (s == GUARD) && (c == BL_LAST);
  endfunction

  function automatic logic [6:0] decode(logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  assign wr_ready = ~pending_full;
  assign xfer     = wr_valid & ~pending_full;
  assign fe_now   = is_last(state, idx, cnt);

  // State register. Outputs are registered from the next-state values, so they
  // line up with the state that holds during the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      segments     <= '0;
      digit_sel    <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      cnt          <= cnt_d;
      active       <= active_d;
      pending      <= pending_d;
      pending_full <= pfull_d;
      segments     <= seg_d;
      digit_sel    <= dsel_d;
      frame_done   <= fd_d;
    end
  end

  // Next-state: scan sequencing and buffer movement.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end
        SCAN: begin
          if (cnt == DW_LAST) begin
            cnt_d = '0;
            if (BLANK > 0) state_d = GUARD;
            else           idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        GUARD: begin
          if (cnt == BL_LAST) begin
            cnt_d   = '0;
            state_d = SCAN;
            idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A write lands directly in active when nothing is being displayed or
    // the frame is turning over. Otherwise it is parked in pending.
    // A transfer and a commit are exclusive because a transfer needs pending empty.
    active_d  = active;
    pending_d = pending;
    pfull_d   = pending_full;
    if (xfer) begin
      if (state == IDLE || fe_now) active_d = wr_data;
      else begin
        pending_d = wr_data;
        pfull_d   = 1'b1;
      end
    end else if (pending_full && (fe_now || state == IDLE || state_d == IDLE)) begin
      active_d = pending;
      pfull_d  = 1'b0;
    end
  end

  // Output decode from next-state values.
  logic [NUM_DIGITS-1:0] lz_blank;
  always_comb begin
    logic zero_above;
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (active_d[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above;
    end
  end

  always_comb begin
    seg_d  = '0;
    dsel_d = '0;
    fd_d   = is_last(state_d, idx_d, cnt_d);
    if (state_d == SCAN) begin
      dsel_d = NUM_DIGITS'(1) << idx_d;
`ifdef LEADING_ZERO_BLANK_EN
      seg_d  = lz_blank[idx_d] ? 7'h00 : decode(active_d[4*idx_d +: 4]);
`else
      seg_d  = decode(active_d[4*idx_d +: 4]);
`endif
    end
  end

`ifndef LEADING_ZERO_BLANK_EN
  logic unused_lz;
  assign unused_lz = ^lz_blank;
`endif

endmodule
